tx_initiated_point_test_rx: RTL
===============================

# tx_initiated_point_test_rx

Partner-side responder for the TX-initiated D2C point test. It consumes the sideband requests the TX-side point-test FSM issues (start, LFSR clear, result, end), controls the local mainband/valid-train comparators, and returns the matching responses. The per-lane comparison result travels back in the result response. It sits between the sideband RX decoder/TX encoder and the RX pattern comparators, under LTSM control.

## Interface
- TIMEOUT_CYCLES, 800000: wait-state timeout in clk cycles. Used only with PT_RX_TIMEOUT_EN.
- NUM_LANES, 16: comparator lanes. Must be ≤16, since the result is carried in a 16-bit field.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  LTSM enable; low aborts to IDLE from any state
- i_sideband_message  in  4  decoded incoming message code
- i_sideband_data  in  16  incoming message data: bit0 data_pattern (0 mainband, 1 valtrain), bit1 burst_count, bit2 comparison_mode
- i_sideband_message_valid  in  1  one-cycle qualifier for message/data
- i_busy_negedge_detected  in  1  sideband TX finished sending the current message
- i_comparison_result  in  NUM_LANES  per-lane pass (1) from comparators, stable while o_comparator_en=1
- o_sideband_message  out  4  response code to sideband TX
- o_sideband_data  out  16  response data; zero-extended lane result in the result response
- o_valid_tx  out  1  response pending for sideband TX
- o_comparator_en  out  1  enables the RX comparators
- o_lfsr_clear  out  1  one-cycle pulse that resets the RX LFSR/comparator accumulators
- o_valtrain_sel  out  1  latched data_pattern (selects valid-train vs mainband comparator)
- o_test_ack_rx  out  1  test complete, to LTSM
- o_timeout  out  1  sticky timeout flag. Exists only with PT_RX_TIMEOUT_EN.

## Operation
- Message codes: 0001 start req, 0010 start resp, 0011 clear req, 0100 clear resp, 0101 result req, 0110 result resp, 0111 end req, 1000 end resp.
- A message is accepted only when i_sideband_message_valid=1 and the code matches the current wait state. All other messages are ignored.
- IDLE: all outputs 0. If i_en=1, go to WAIT_START.
- WAIT_START, on start req:
  - Latch i_sideband_data[2:0].
  - o_valtrain_sel←bit0.
  - Go to START_RESP.
- START_RESP:
  - o_sideband_message=0010, o_valid_tx=1.
  - On i_busy_negedge_detected, go to WAIT_CLEAR.
- WAIT_CLEAR, on clear req:
  - Pulse o_lfsr_clear.
  - Go to CLEAR_RESP (message 0100).
  - Then go to COMPARE.
- COMPARE:
  - o_comparator_en=1.
  - On result req: snapshot i_comparison_result into o_sideband_data[NUM_LANES-1:0], upper bits 0.
  - Drop o_comparator_en in the same cycle the snapshot is registered.
  - Go to RESULT_RESP (message 0110), then WAIT_END.
- WAIT_END, on end req: go to END_RESP (message 1000, data 0).
- END_RESP, on i_busy_negedge_detected: go to TEST_FINISHED.
- TEST_FINISHED:
  - o_test_ack_rx=1, o_sideband_message=0, o_valid_tx=0.
  - Hold until i_en=0, then go to IDLE.
- o_valid_tx:
  - Set on entry to any *_RESP state.
  - Cleared on i_busy_negedge_detected. If both occur in the same cycle, clear wins.
  - Never set in WAIT/COMPARE/IDLE/TEST_FINISHED.
- Abort: i_en=0 in any state forces IDLE next cycle.
  - All outputs clear, including o_valid_tx and the latched config.
  - o_timeout is excepted: it clears only on reset or a new i_en rising.

## Timing
- Reset value of every output: 0. The state resets to IDLE.
- All outputs are registered.
- Response code and o_valid_tx appear 1 cycle after the accepted request cycle.
- o_lfsr_clear is high exactly 1 cycle, coincident with CLEAR_RESP entry.
- Response message is held until i_busy_negedge_detected. The next wait state is entered 1 cycle later.
- A request arriving while in a *_RESP state is ignored. The TX side never issues one before the response.
- Result snapshot uses i_comparison_result sampled in the request cycle.

## Configuration
- PT_RX_TIMEOUT_EN defined:
  - A 20-bit counter runs in WAIT_START, WAIT_CLEAR, COMPARE and WAIT_END.
  - The counter resets on every state change.
  - At TIMEOUT_CYCLES-1: set o_timeout and go to IDLE.
- Undefined: no counter, and the o_timeout port is absent. Wait states hold indefinitely.

## Structure
- Shared package pt_pkg holds:
  - the message-code localparams;
  - the state enum;
  - the sideband data bit-index constants, which the TX-side point-test block also uses.
- Sub-module pt_rx_timeout (counter plus compare), instantiated only under PT_RX_TIMEOUT_EN.

## Test plan
- Full handshake: drive 0001 (data 0x0000), 0011, 0101, 0111, with a busy negedge after each response.
  - Responses must be 0010, 0100, 0110, 1000.
  - o_test_ack_rx=1.
  - o_lfsr_clear pulses once.
- Valtrain config: start req with data 0x0007 → o_valtrain_sel=1 until TEST_FINISHED.
- Result capture:
  - i_comparison_result=0xA5F0 in the result-req cycle → o_sideband_data=0xA5F0 with 0110.
  - o_comparator_en falls the next cycle.
- Out-of-order: in WAIT_START, drive 0101 → no state change, o_valid_tx stays 0.
- Abort: i_en low during COMPARE → IDLE next cycle, all outputs 0. A restart must repeat the full handshake.
- Timeout (PT_RX_TIMEOUT_EN, TIMEOUT_CYCLES=100): no clear req after the start resp → o_timeout=1 at cycle 100 of WAIT_CLEAR, state goes to IDLE.

Source files
------------

// File: rtl/pt_pkg.sv
// Shared definitions for the TX-initiated point-test blocks: sideband message codes,
// sideband data bit positions and the RX responder state encoding.
package pt_pkg;

  localparam logic [3:0] MsgStartReq   = 4'b0001;
  localparam logic [3:0] MsgStartResp  = 4'b0010;
  localparam logic [3:0] MsgClearReq   = 4'b0011;
  localparam logic [3:0] MsgClearResp  = 4'b0100;
  localparam logic [3:0] MsgResultReq  = 4'b0101;
  localparam logic [3:0] MsgResultResp = 4'b0110;
  localparam logic [3:0] MsgEndReq     = 4'b0111;
  localparam logic [3:0] MsgEndResp    = 4'b1000;

  // Bit positions inside the 16-bit sideband data word.
  localparam int unsigned PtDataPatternBit = 0;
  localparam int unsigned PtBurstCountBit  = 1;
  localparam int unsigned PtCompModeBit    = 2;

  typedef enum logic [3:0] {
    StIdle,
    StWaitStart,
    StStartResp,
    StWaitClear,
    StClearResp,
    StCompare,
    StResultResp,
    StWaitEnd,
    StEndResp,
    StTestFinished
  } pt_rx_state_e;

  function automatic logic pt_is_wait_state(pt_rx_state_e s);
    return (s == StWaitStart) || (s == StWaitClear) || (s == StCompare) || (s == StWaitEnd);
  endfunction

endpackage

// File: rtl/pt_rx_timeout.sv
// Wait-state watchdog for the point-test responder: counts cycles spent in one wait state
// and flags expiry after TIMEOUT_CYCLES of them.
module pt_rx_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 800000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic expired
);

  localparam logic [19:0] Limit = 20'(TIMEOUT_CYCLES - 1);

  logic [19:0] cnt_q, cnt_d;

  assign expired = run && (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q + 20'd1;
    if (!run || restart || expired) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_initiated_point_test_rx.sv
// Partner-side responder for the TX-initiated D2C point test. Define PT_RX_TIMEOUT_EN to add
// the wait-state watchdog and the sticky o_timeout port.
module tx_initiated_point_test_rx
  import pt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 800000,
  parameter int unsigned NUM_LANES      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic [3:0]           i_sideband_message,
  input  logic [15:0]          i_sideband_data,
  input  logic                 i_sideband_message_valid,
  input  logic                 i_busy_negedge_detected,
  input  logic [NUM_LANES-1:0] i_comparison_result,
  output logic [3:0]           o_sideband_message,
  output logic [15:0]          o_sideband_data,
  output logic                 o_valid_tx,
  output logic                 o_comparator_en,
  output logic                 o_lfsr_clear,
  output logic                 o_valtrain_sel,
  output logic                 o_test_ack_rx
`ifdef PT_RX_TIMEOUT_EN
  ,
  output logic                 o_timeout
`endif
);

  pt_rx_state_e state_q, state_d, fsm_next;
  logic [3:0]   msg_q, msg_d;
  logic [15:0]  data_q, data_d;
  logic         valid_q, valid_d;
  logic         cmp_en_q, cmp_en_d;
  logic         lfsr_clear_q, lfsr_clear_d;
  logic [2:0]   cfg_q, cfg_d;
  logic         ack_q, ack_d;
  logic         timeout_hit;

  logic req_start, req_clear, req_result, req_end, busy_done;

  assign req_start  = i_sideband_message_valid && (i_sideband_message == MsgStartReq);
  assign req_clear  = i_sideband_message_valid && (i_sideband_message == MsgClearReq);
  assign req_result = i_sideband_message_valid && (i_sideband_message == MsgResultReq);
  assign req_end    = i_sideband_message_valid && (i_sideband_message == MsgEndReq);
  assign busy_done  = i_busy_negedge_detected;

  // Only the pattern bit drives hardware here; the rest is held for the partner's use.
  logic unused_bits;
  assign unused_bits = ^{cfg_q[PtCompModeBit:PtBurstCountBit], i_sideband_data[15:3]};

  always_comb begin
    state_d      = state_q;
    fsm_next     = state_q;
    msg_d        = msg_q;
    data_d       = data_q;
    valid_d      = valid_q;
    cmp_en_d     = cmp_en_q;
    lfsr_clear_d = 1'b0;
    cfg_d        = cfg_q;
    ack_d        = ack_q;

    // Entering a response: a busy strobe in the same cycle wins over the new valid.
    unique case (state_q)
      StIdle: begin
        if (i_en) state_d = StWaitStart;
      end
      StWaitStart: begin
        if (req_start) begin
          cfg_d   = i_sideband_data[PtCompModeBit:PtDataPatternBit];
          msg_d   = MsgStartResp;
          data_d  = '0;
          valid_d = ~busy_done;
          state_d = StStartResp;
        end
      end
      StStartResp: begin
        if (busy_done) begin
          msg_d   = '0;
          valid_d = 1'b0;
          state_d = StWaitClear;
        end
      end
      StWaitClear: begin
        if (req_clear) begin
          lfsr_clear_d = 1'b1;
          msg_d        = MsgClearResp;
          data_d       = '0;
          valid_d      = ~busy_done;
          state_d      = StClearResp;
        end
      end
      StClearResp: begin
        if (busy_done) begin
          msg_d    = '0;
          valid_d  = 1'b0;
          cmp_en_d = 1'b1;
          state_d  = StCompare;
        end
      end
      StCompare: begin
        if (req_result) begin
          data_d                 = '0;
          data_d[NUM_LANES-1:0]  = i_comparison_result;
          cmp_en_d               = 1'b0;
          msg_d                  = MsgResultResp;
          valid_d                = ~busy_done;
          state_d                = StResultResp;
        end
      end
      StResultResp: begin
        if (busy_done) begin
          msg_d   = '0;
          data_d  = '0;
          valid_d = 1'b0;
          state_d = StWaitEnd;
        end
      end
      StWaitEnd: begin
        if (req_end) begin
          msg_d   = MsgEndResp;
          data_d  = '0;
          valid_d = ~busy_done;
          state_d = StEndResp;
        end
      end
      StEndResp: begin
        if (busy_done) begin
          msg_d   = '0;
          data_d  = '0;
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = StTestFinished;
        end
      end
      StTestFinished: begin
        state_d = StTestFinished;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    fsm_next = state_d;

    if (!i_en || timeout_hit) begin
      state_d  = StIdle;
      msg_d    = '0;
      data_d   = '0;
      valid_d  = 1'b0;
      cmp_en_d = 1'b0;
      cfg_d    = '0;
      ack_d    = 1'b0;
      lfsr_clear_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      msg_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      cmp_en_q     <= 1'b0;
      lfsr_clear_q <= 1'b0;
      cfg_q        <= '0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      msg_q        <= msg_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      cmp_en_q     <= cmp_en_d;
      lfsr_clear_q <= lfsr_clear_d;
      cfg_q        <= cfg_d;
      ack_q        <= ack_d;
    end
  end

  assign o_sideband_message = msg_q;
  assign o_sideband_data    = data_q;
  assign o_valid_tx         = valid_q;
  assign o_comparator_en    = cmp_en_q;
  assign o_lfsr_clear       = lfsr_clear_q;
  assign o_valtrain_sel     = cfg_q[PtDataPatternBit];
  assign o_test_ack_rx      = ack_q;

`ifdef PT_RX_TIMEOUT_EN
  logic wd_run, wd_restart;
  logic en_q, timeout_q, timeout_d;

  assign wd_run     = pt_is_wait_state(state_q);
  assign wd_restart = (fsm_next != state_q);

  pt_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (wd_run),
    .restart(wd_restart),
    .expired(timeout_hit)
  );

  // Sticky across aborts; only a fresh enable clears it.
  always_comb begin
    timeout_d = timeout_q | timeout_hit;
    if (i_en && !en_q) timeout_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      en_q      <= i_en;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  localparam int unsigned UnusedTimeoutCycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

endmodule
